// File: rtl/wb_lsu_master.sv
// wb_lsu_master: load/store unit to Wishbone classic-cycle initiator.
// Handles one access at a time. Store data is placed on the addressed byte
// lanes, and load data is extracted and extended. Misaligned accesses and
// bus timeouts come back as error responses.
//
// state  | meaning
// IDLE   | ready for a request
// BUS    | Wishbone cycle in flight, waiting for ack or timeout
// RESP   | response held until the consumer takes it
module wb_lsu_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Last count value before the cycle is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [7:0]            to_cnt;

    logic                  misaligned;
    logic [3:0]            sel_next;
    logic [DATA_WIDTH-1:0] dat_next;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign req_ready = (state == S_IDLE);

    // Alignment check and lane/data steering for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        sel_next   = 4'b1111;
        dat_next   = req_wdata;
        case (req_size)
            2'b00: begin
                sel_next = 4'b0001 << req_addr[1:0];
                dat_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                sel_next   = req_addr[1] ? 4'b1100 : 4'b0011;
                dat_next   = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (req_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane(s) out of the read data and extend.
    // The latched byte address lives in wb_adr_o during the bus cycle.
    always_comb begin
        case (wb_adr_o[1:0])
            2'd0:    lane_byte = wb_dat_i[7:0];
            2'd1:    lane_byte = wb_dat_i[15:8];
            2'd2:    lane_byte = wb_dat_i[23:16];
            default: lane_byte = wb_dat_i[31:24];
        endcase
        lane_half = wb_adr_o[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~uns_q & lane_half[15]}}, lane_half};
            default: load_ext = wb_dat_i;
        endcase
    end

    // Sequencer: request capture, bus cycle with timeout, response hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            to_cnt     <= 8'd0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'b0000;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wb_adr_o <= req_addr;
                        wb_we_o  <= req_we;
                        wb_sel_o <= sel_next;
                        wb_dat_o <= dat_next;
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        to_cnt   <= 8'd0;
                        if (misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= S_BUS;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the expiry cycle still counts as completion.
                    if (wb_ack_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wb_we_o ? '0 : load_ext;
                    end else if (to_cnt == TO_LAST) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a small Wishbone slave model whose
// ack behaviour is selectable per access.
module tb_wb_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: registered ack, 1: never ack, 2: ack in the 4th strobe cycle
    int slave_mode = 0;
    int slave_cnt  = 0;

    // observations of the last transaction
    logic [31:0] o_rdata;
    logic        o_err;
    int          o_lat;
    int          o_cyc;
    logic [3:0]  o_sel;
    logic [31:0] o_dat;
    logic        o_we;
    logic [15:0] o_adr;

    wb_lsu_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!wb_cyc_o || !wb_stb_o) begin
            wb_ack_i  <= 1'b0;
            slave_cnt <= 0;
        end else if (wb_ack_i) begin
            wb_ack_i <= 1'b0;
        end else begin
            slave_cnt <= slave_cnt + 1;
            case (slave_mode)
                0:       wb_ack_i <= 1'b1;
                2:       wb_ack_i <= (slave_cnt == 2);
                default: wb_ack_i <= 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat is the cycle (1 = first cycle after the
    // handshake edge) in which resp_valid is first seen, 0 if never.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [15:0] addr, input logic [31:0] wdata);
        bit seen = 0;
        @(negedge clk);
        check("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        o_lat = 0; o_cyc = 0; o_sel = 4'h0; o_dat = 32'h0; o_we = 1'b0; o_adr = 16'h0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (wb_cyc_o || wb_stb_o) o_cyc++;
            if (wb_stb_o && !seen) begin
                seen = 1;
                o_sel = wb_sel_o; o_dat = wb_dat_o; o_we = wb_we_o; o_adr = wb_adr_o;
            end
            if (resp_valid) begin
                o_lat = i;
                break;
            end
        end
        o_rdata = resp_rdata;
        o_err   = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_cleared", {31'b0, resp_valid}, 32'd0);
        check("req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        check("rst_adr", {16'b0, wb_adr_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // load word
        slave_mode = 0; wb_dat_i = 32'hDEADBEEF;
        run_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
        check("lw_sel", {28'b0, o_sel}, 32'hF);
        check("lw_we", {31'b0, o_we}, 32'd0);
        check("lw_adr", {16'b0, o_adr}, 32'h0010);
        check("lw_rdata", o_rdata, 32'hDEADBEEF);
        check("lw_err", {31'b0, o_err}, 32'd0);
        check("lw_latency", o_lat, 32'd3);
        check("lw_cyc_cycles", o_cyc, 32'd2);

        // store byte, upper wdata bits must not leak
        wb_dat_i = 32'hFFFFFFFF;
        run_req(1'b1, 2'b00, 1'b0, 16'h0013, 32'h123456A5);
        check("sb_dat", o_dat, 32'hA5A5A5A5);
        check("sb_sel", {28'b0, o_sel}, 32'h8);
        check("sb_we", {31'b0, o_we}, 32'd1);
        check("sb_adr", {16'b0, o_adr}, 32'h0013);
        check("sb_err", {31'b0, o_err}, 32'd0);
        check("sb_rdata", o_rdata, 32'd0);

        // store half to upper lanes
        run_req(1'b1, 2'b01, 1'b0, 16'h0022, 32'h5555BEEF);
        check("sh_dat", o_dat, 32'hBEEFBEEF);
        check("sh_sel", {28'b0, o_sel}, 32'hC);

        // byte / half loads with extension
        wb_dat_i = 32'h12F45678;
        run_req(1'b0, 2'b00, 1'b0, 16'h0002, 32'h0);
        check("lb_s_rdata", o_rdata, 32'hFFFFFFF4);
        check("lb_s_sel", {28'b0, o_sel}, 32'h4);
        run_req(1'b0, 2'b00, 1'b1, 16'h0002, 32'h0);
        check("lb_u_rdata", o_rdata, 32'h000000F4);
        run_req(1'b0, 2'b01, 1'b0, 16'h0002, 32'h0);
        check("lh_hi_rdata", o_rdata, 32'h000012F4);
        check("lh_hi_sel", {28'b0, o_sel}, 32'hC);
        wb_dat_i = 32'h12348001;
        run_req(1'b0, 2'b01, 1'b0, 16'h0000, 32'h0);
        check("lh_lo_s_rdata", o_rdata, 32'hFFFF8001);
        check("lh_lo_s_sel", {28'b0, o_sel}, 32'h3);
        run_req(1'b0, 2'b01, 1'b1, 16'h0000, 32'h0);
        check("lh_lo_u_rdata", o_rdata, 32'h00008001);
        run_req(1'b0, 2'b00, 1'b0, 16'h0001, 32'h0);
        check("lb_lane1_rdata", o_rdata, 32'hFFFFFF80);

        // misaligned accesses
        run_req(1'b0, 2'b01, 1'b0, 16'h0001, 32'h0);
        check("mis_h_err", {31'b0, o_err}, 32'd1);
        check("mis_h_rdata", o_rdata, 32'd0);
        check("mis_h_latency", o_lat, 32'd1);
        check("mis_h_cyc", o_cyc, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 16'h0006, 32'h0);
        check("mis_w_err", {31'b0, o_err}, 32'd1);
        check("mis_w_latency", o_lat, 32'd1);
        check("mis_w_cyc", o_cyc, 32'd0);
        run_req(1'b1, 2'b11, 1'b0, 16'h0000, 32'h0);
        check("mis_sz3_err", {31'b0, o_err}, 32'd1);
        check("mis_sz3_cyc", o_cyc, 32'd0);

        // timeout with no ack
        slave_mode = 1; wb_dat_i = 32'hCAFEBABE;
        run_req(1'b0, 2'b10, 1'b0, 16'h0004, 32'h0);
        check("to_cyc_cycles", o_cyc, 32'd4);
        check("to_err", {31'b0, o_err}, 32'd1);
        check("to_rdata", o_rdata, 32'd0);
        check("to_latency", o_lat, 32'd5);

        // ack coinciding with expiry completes normally
        slave_mode = 2;
        run_req(1'b0, 2'b10, 1'b0, 16'h0004, 32'h0);
        check("late_ack_cyc", o_cyc, 32'd4);
        check("late_ack_err", {31'b0, o_err}, 32'd0);
        check("late_ack_rdata", o_rdata, 32'hCAFEBABE);
        check("late_ack_latency", o_lat, 32'd5);

        // reset while the bus cycle is in flight
        slave_mode = 1;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_addr = 16'h0008; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_bus_cyc", {31'b0, wb_cyc_o}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("mid_rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        slave_mode = 0; wb_dat_i = 32'h0BADF00D;
        run_req(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0);
        check("post_rst_rdata", o_rdata, 32'h0BADF00D);
        check("post_rst_err", {31'b0, o_err}, 32'd0);
        check("post_rst_latency", o_lat, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
